// File: rtl/pulse_stream_transmitter_if.sv
// Symbol push stream: {eos, level, duration} words offered with valid/ready.
interface pulse_stream_transmitter_if #(
    parameter int unsigned DUR_W = 12
);
    logic               wr_valid;
    logic [DUR_W+1:0]   wr_data;
    logic               wr_ready;

    modport master (output wr_valid, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/pulse_stream_transmitter.sv
// FIFO-fed pulse transmitter: each symbol has its own level, duration and
// end-of-stream flag; streams (popping) or replays the FIFO in loop mode.
module pulse_stream_transmitter #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned DUR_W   = 12,
    parameter int unsigned PRESC_W = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         flush,
    input  logic                         loop_mode,
    input  logic [7:0]                   loop_count,
    input  logic [PRESC_W-1:0]           prescaler,
    input  logic                         idle_level,
    input  logic                         invert,
    input  logic                         carrier_en,
    input  logic [15:0]                  carrier_half,
    input  logic [$clog2(DEPTH+1)-1:0]   low_water,
    pulse_stream_transmitter_if.slave    wr,
    output logic [$clog2(DEPTH+1)-1:0]   fill,
    output logic                         pulse_out,
    output logic                         active,
    output logic                         irq_done,
    output logic                         irq_underflow,
    output logic                         irq_low_water,
    output logic                         irq_loop
);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned FILL_W = $clog2(DEPTH+1);
    localparam int unsigned TICK_W = 2**PRESC_W;

    typedef struct packed {
        logic             eos;
        logic             level;
        logic [DUR_W-1:0] dur;
    } sym_t;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_e;

    sym_t               mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [FILL_W-1:0]  fill_q, rep_idx_q;
    state_e             state_q;
    sym_t               cur_q;
    logic [DUR_W-1:0]   dur_cnt_q;
    logic [TICK_W-1:0]  tick_cnt_q;
    logic [15:0]        car_cnt_q;
    logic               car_phase_q;
    logic [7:0]         pass_q;
    logic               irq_done_q, irq_underflow_q, irq_low_water_q, irq_loop_q;

    logic [TICK_W-1:0]  tick_lim_c;
    logic               full_c, wr_ready_c, push_c, pop_c, flush_c;
    logic               boundary_c, pass_end_c, last_pass_c;
    logic [PTR_W-1:0]   fetch_ptr_c;
    sym_t               next_sym_c;
    logic [FILL_W-1:0]  fill_d_c;

    // Handshake, boundary detection and next-symbol fetch.
    always_comb begin
        tick_lim_c  = ~(~TICK_W'(0) << prescaler);
        full_c      = (fill_q == FILL_W'(DEPTH));
        wr_ready_c  = !full_c && !(loop_mode && (state_q != S_IDLE));
        push_c      = wr.wr_valid && wr_ready_c;
        flush_c     = flush && (state_q == S_IDLE);
        boundary_c  = (state_q == S_RUN) && !stop && (tick_cnt_q == tick_lim_c)
                      && (dur_cnt_q == '0);
        pass_end_c  = cur_q.eos || ((rep_idx_q + FILL_W'(1)) == fill_q);
        last_pass_c = (loop_count != 8'd0) && ((pass_q + 8'd1) == loop_count);
        pop_c       = !loop_mode && !stop && ((state_q == S_LOAD)
                      || (boundary_c && !cur_q.eos && (fill_q != '0)));
        fetch_ptr_c = rd_ptr_q;
        if (loop_mode && boundary_c && !pass_end_c) begin
            fetch_ptr_c = rd_ptr_q + PTR_W'(rep_idx_q) + PTR_W'(1);
        end
        next_sym_c  = mem_q[fetch_ptr_c];
        fill_d_c    = fill_q + FILL_W'(push_c) - FILL_W'(pop_c);
        if (flush_c) begin
            fill_d_c = '0;
        end
    end

    // Symbol storage; emptying is done purely through the pointers.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= sym_t'(wr.wr_data);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            fill_q          <= '0;
            rep_idx_q       <= '0;
            state_q         <= S_IDLE;
            cur_q           <= '0;
            dur_cnt_q       <= '0;
            tick_cnt_q      <= '0;
            car_cnt_q       <= '0;
            car_phase_q     <= 1'b0;
            pass_q          <= '0;
            irq_done_q      <= 1'b0;
            irq_underflow_q <= 1'b0;
            irq_low_water_q <= 1'b0;
            irq_loop_q      <= 1'b0;
        end else begin
            irq_done_q      <= 1'b0;
            irq_underflow_q <= 1'b0;
            irq_loop_q      <= 1'b0;
            irq_low_water_q <= !loop_mode && (state_q != S_IDLE)
                               && (fill_q > low_water) && (fill_d_c <= low_water);
            fill_q          <= fill_d_c;
            if (flush_c) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end

            // Carrier is preloaded in LOAD so the first low half spans carrier_half+1 clocks.
            if (state_q == S_RUN) begin
                if (car_cnt_q == '0) begin
                    car_phase_q <= !car_phase_q;
                    car_cnt_q   <= carrier_half;
                end else begin
                    car_cnt_q   <= car_cnt_q - 16'd1;
                end
            end else begin
                car_cnt_q   <= (state_q == S_LOAD) ? carrier_half : 16'd0;
                car_phase_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (fill_q != '0) state_q <= S_LOAD;
                        else              irq_underflow_q <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (stop) begin
                        state_q <= S_IDLE;
                    end else begin
                        cur_q      <= next_sym_c;
                        dur_cnt_q  <= next_sym_c.dur;
                        tick_cnt_q <= '0;
                        rep_idx_q  <= '0;
                        pass_q     <= '0;
                        state_q    <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        state_q <= S_IDLE;
                    end else if (boundary_c) begin
                        // Next symbol is latched in the expiry cycle: no gap between symbols.
                        cur_q      <= next_sym_c;
                        dur_cnt_q  <= next_sym_c.dur;
                        tick_cnt_q <= '0;
                        if (loop_mode) begin
                            if (pass_end_c) begin
                                irq_loop_q <= 1'b1;
                                pass_q     <= pass_q + 8'd1;
                                rep_idx_q  <= '0;
                                if (last_pass_c) begin
                                    state_q    <= S_IDLE;
                                    irq_done_q <= 1'b1;
                                end
                            end else begin
                                rep_idx_q <= rep_idx_q + FILL_W'(1);
                            end
                        end else if (cur_q.eos) begin
                            state_q    <= S_IDLE;
                            irq_done_q <= 1'b1;
                        end else if (fill_q == '0) begin
                            state_q         <= S_IDLE;
                            irq_underflow_q <= 1'b1;
                        end
                    end else if (tick_cnt_q == tick_lim_c) begin
                        tick_cnt_q <= '0;
                        dur_cnt_q  <= dur_cnt_q - DUR_W'(1);
                    end else begin
                        tick_cnt_q <= tick_cnt_q + TICK_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign wr.wr_ready     = wr_ready_c;
    assign fill            = fill_q;
    assign active          = (state_q == S_RUN);
    assign irq_done        = irq_done_q;
    assign irq_underflow   = irq_underflow_q;
    assign irq_low_water   = irq_low_water_q;
    assign irq_loop        = irq_loop_q;
    assign pulse_out       = ((state_q == S_RUN) ? (cur_q.level & (car_phase_q | !carrier_en))
                                                 : idle_level) ^ invert;
endmodule

// File: tb/tb_pulse_stream_transmitter.sv
// Directed bench for pulse_stream_transmitter; inputs change and outputs are
// sampled on the falling clock edge.
module tb_pulse_stream_transmitter;
    logic        clk;
    logic        rst_n;
    logic        start, stop, flush, loop_mode;
    logic [7:0]  loop_count;
    logic [3:0]  prescaler;
    logic        idle_level, invert, carrier_en;
    logic [15:0] carrier_half;
    logic [4:0]  low_water;
    logic [4:0]  fill;
    logic        pulse_out, active, irq_done, irq_underflow, irq_low_water, irq_loop;

    int n_checks = 0;
    int n_errors = 0;
    int cnt_done = 0, cnt_uf = 0, cnt_loop = 0, cnt_lw = 0;
    int snap_done, snap_uf, snap_loop, snap_lw;

    pulse_stream_transmitter_if #(.DUR_W(12)) wr_if ();

    pulse_stream_transmitter #(.DEPTH(16), .DUR_W(12), .PRESC_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .flush(flush),
        .loop_mode(loop_mode), .loop_count(loop_count), .prescaler(prescaler),
        .idle_level(idle_level), .invert(invert), .carrier_en(carrier_en),
        .carrier_half(carrier_half), .low_water(low_water), .wr(wr_if),
        .fill(fill), .pulse_out(pulse_out), .active(active), .irq_done(irq_done),
        .irq_underflow(irq_underflow), .irq_low_water(irq_low_water), .irq_loop(irq_loop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Interrupt pulse counters.
    always @(posedge clk) begin
        cnt_done <= cnt_done + int'(irq_done);
        cnt_uf   <= cnt_uf   + int'(irq_underflow);
        cnt_loop <= cnt_loop + int'(irq_loop);
        cnt_lw   <= cnt_lw   + int'(irq_low_water);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic eos, input logic lvl, input logic [11:0] d);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data  = {eos, lvl, d};
        @(negedge clk);
        wr_if.wr_valid = 1'b0;
    endtask

    task automatic kick();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_pat(input string tag, input int n, input logic [31:0] pat);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk(tag, 32'(pulse_out), 32'(pat[i]));
        end
    endtask

    task automatic snap();
        snap_done = cnt_done; snap_uf = cnt_uf; snap_loop = cnt_loop; snap_lw = cnt_lw;
    endtask

    initial begin
        logic seen;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; flush = 1'b0; loop_mode = 1'b0;
        loop_count = 8'd0; prescaler = 4'd0; idle_level = 1'b0; invert = 1'b0;
        carrier_en = 1'b0; carrier_half = 16'd0; low_water = 5'd0;
        wr_if.wr_valid = 1'b0; wr_if.wr_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_fill", 32'(fill), 0);
        chk("rst_active", 32'(active), 0);
        chk("rst_ready", 32'(wr_if.wr_ready), 1);
        chk("rst_pulse", 32'(pulse_out), 0);
        chk("rst_irqs", 32'({irq_done, irq_underflow, irq_low_water, irq_loop}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Three-symbol stream: high 4, low 2, high 1.
        push(1'b0, 1'b1, 12'd3); push(1'b0, 1'b0, 12'd1); push(1'b1, 1'b1, 12'd0);
        chk("t1_fill3", 32'(fill), 3);
        snap();
        kick();
        chk("t1_load_idle", 32'(pulse_out), 0);
        run_pat("t1_pat", 7, 32'b1001111);
        @(negedge clk);
        chk("t1_done", 32'(irq_done), 1);
        chk("t1_active", 32'(active), 0);
        chk("t1_fill0", 32'(fill), 0);
        chk("t1_idle", 32'(pulse_out), 0);
        repeat (2) @(negedge clk);
        chk("t1_done_cnt", 32'(cnt_done - snap_done), 1);

        // Start with empty FIFO.
        kick();
        chk("t2_empty_uf", 32'(irq_underflow), 1);
        chk("t2_empty_active", 32'(active), 0);

        // Underflow at second boundary.
        idle_level = 1'b1;
        push(1'b0, 1'b1, 12'd1); push(1'b0, 1'b0, 12'd0);
        kick();
        chk("t2_load_idle", 32'(pulse_out), 1);
        run_pat("t2_pat", 3, 32'b011);
        chk("t2_active_run", 32'(active), 1);
        @(negedge clk);
        chk("t2_uf", 32'(irq_underflow), 1);
        chk("t2_active_fall", 32'(active), 0);
        chk("t2_idle", 32'(pulse_out), 1);
        idle_level = 1'b0;
        @(negedge clk);

        // Loop replay: 3 passes of {high, low}, 2 clocks each.
        loop_mode = 1'b1; loop_count = 8'd3; prescaler = 4'd1;
        push(1'b0, 1'b1, 12'd0); push(1'b0, 1'b0, 12'd0);
        snap();
        kick();
        chk("t3_ready_load", 32'(wr_if.wr_ready), 0);
        run_pat("t3_pat", 12, 32'b0011_0011_0011);
        chk("t3_ready_run", 32'(wr_if.wr_ready), 0);
        chk("t3_fill_run", 32'(fill), 2);
        @(negedge clk);
        chk("t3_done", 32'(irq_done), 1);
        chk("t3_fill_after", 32'(fill), 2);
        @(negedge clk);
        chk("t3_loop_cnt", 32'(cnt_loop - snap_loop), 3);
        chk("t3_done_cnt", 32'(cnt_done - snap_done), 1);
        loop_mode = 1'b0; prescaler = 4'd0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("t3_flush", 32'(fill), 0);

        // Full FIFO, low-water crossing, concurrent push and pop.
        low_water = 5'd4;
        for (int i = 0; i < 16; i++) push(1'b0, 1'(i % 2), 12'd0);
        chk("t4_full", 32'(fill), 16);
        chk("t4_ready_full", 32'(wr_if.wr_ready), 0);
        snap();
        kick();
        @(negedge clk);
        chk("t4_fill15", 32'(fill), 15);
        wr_if.wr_valid = 1'b1; wr_if.wr_data = {1'b1, 1'b1, 12'd0};
        @(negedge clk);
        wr_if.wr_valid = 1'b0;
        chk("t4_pushpop", 32'(fill), 15);
        repeat (10) @(negedge clk);
        chk("t4_fill5", 32'(fill), 5);
        chk("t4_lw_early", 32'(irq_low_water), 0);
        @(negedge clk);
        chk("t4_fill4", 32'(fill), 4);
        chk("t4_lw", 32'(irq_low_water), 1);
        seen = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            seen = irq_done;
        end
        chk("t4_done_seen", 32'(seen), 1);
        @(negedge clk);
        chk("t4_lw_cnt", 32'(cnt_lw - snap_lw), 1);
        chk("t4_uf_cnt", 32'(cnt_uf - snap_uf), 0);
        chk("t4_fill_end", 32'(fill), 0);

        // Carrier on a single long high symbol, plain then inverted.
        carrier_en = 1'b1; carrier_half = 16'd2;
        push(1'b1, 1'b1, 12'd11);
        kick();
        run_pat("t5_car", 12, 32'b111000111000);
        @(negedge clk);
        chk("t5_idle", 32'(pulse_out), 0);
        invert = 1'b1;
        push(1'b1, 1'b1, 12'd11);
        chk("t5_inv_idle", 32'(pulse_out), 1);
        kick();
        run_pat("t5_car_inv", 12, 32'b000111000111);
        @(negedge clk);
        chk("t5_inv_after", 32'(pulse_out), 1);
        invert = 1'b0; carrier_en = 1'b0;

        // Stop mid-symbol keeps the remaining FIFO contents.
        push(1'b0, 1'b1, 12'd9); push(1'b1, 1'b1, 12'd2);
        snap();
        kick();
        repeat (3) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("t6_stop_active", 32'(active), 0);
        chk("t6_stop_pulse", 32'(pulse_out), 0);
        chk("t6_stop_fill", 32'(fill), 1);
        repeat (2) @(negedge clk);
        chk("t6_stop_noirq", 32'((cnt_done - snap_done) + (cnt_uf - snap_uf)), 0);
        kick();
        run_pat("t6_resume", 3, 32'b111);
        @(negedge clk);
        chk("t6_resume_done", 32'(irq_done), 1);

        // Reset mid-RUN.
        push(1'b0, 1'b1, 12'd20); push(1'b1, 1'b0, 12'd0);
        kick();
        repeat (3) @(negedge clk);
        chk("t7_running", 32'(active), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t7_fill", 32'(fill), 0);
        chk("t7_active", 32'(active), 0);
        chk("t7_irqs", 32'({irq_done, irq_underflow, irq_low_water, irq_loop}), 0);
        chk("t7_ready", 32'(wr_if.wr_ready), 1);
        rst_n = 1'b1;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
